// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared widths, limits and FSM states for seq_divider
package seq_divider_pkg;

  localparam int DIV_WIDTH_M = 16;
  localparam int DIV_WIDTH_P = 2 * DIV_WIDTH_M;
  localparam int DIV_CNT_W   = $clog2(DIV_WIDTH_M) + 1;

  // Largest positive / most negative quotient magnitudes a signed WIDTH_M result can carry
  localparam logic [DIV_WIDTH_M-1:0] DIV_Q_MAX_POS = 16'h7FFF;
  localparam logic [DIV_WIDTH_M-1:0] DIV_Q_MAX_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

endpackage

// File: rtl/seq_divider_datapath.sv
// rtl/seq_divider_datapath.sv - magnitude restoring-division datapath with sign fix-up
module seq_divider_datapath
  import seq_divider_pkg::*;
#(
  parameter int WIDTH_M = DIV_WIDTH_M,
  parameter int WIDTH_P = DIV_WIDTH_P,
  parameter int CNT_W   = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_fix,
  input  logic [WIDTH_P-1:0] i_dividend,
  input  logic [WIDTH_M-1:0] i_divisor,
  output logic               o_count_done,
  output logic               o_divisor_zero,
  output logic [WIDTH_M-1:0] o_quotient,
  output logic [WIDTH_M-1:0] o_remainder,
  output logic               o_div_by_zero,
  output logic               o_overflow
);

  logic [WIDTH_M-1:0] r_rem;
  logic [WIDTH_M-1:0] r_quo;
  logic [WIDTH_M-1:0] r_d;
  logic [WIDTH_M-1:0] r_dvd_lo;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf_u;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_dz;
  logic [WIDTH_M-1:0] r_quotient;
  logic [WIDTH_M-1:0] r_remainder;
  logic               r_div_by_zero;
  logic               r_overflow;

  logic [WIDTH_P-1:0] w_dvd_mag;
  logic [WIDTH_M-1:0] w_dvs_mag;
  logic [WIDTH_M:0]   w_shift;
  logic [WIDTH_M+1:0] w_trial;
  logic               w_q_big;
  logic               w_ovf;

  // Unsigned magnitudes: the most negative values map onto their exact unsigned magnitude
  assign w_dvd_mag = i_dividend[WIDTH_P-1] ? (~i_dividend + WIDTH_P'(1)) : i_dividend;
  assign w_dvs_mag = i_divisor[WIDTH_M-1] ? (~i_divisor + WIDTH_M'(1)) : i_divisor;

  // Partial remainder is WIDTH_M+1 wide after the shift; the extra MSB catches the borrow
  assign w_shift = {r_rem, r_quo[WIDTH_M-1]};
  assign w_trial = {1'b0, w_shift} - {2'b00, r_d};

  assign w_q_big = r_sign_q ? (r_quo > DIV_Q_MAX_NEG) : (r_quo > DIV_Q_MAX_POS);
  assign w_ovf   = r_ovf_u | w_q_big;

  assign o_count_done   = (r_count == CNT_W'(WIDTH_M - 1));
  assign o_divisor_zero = (i_divisor == '0);
  assign o_quotient     = r_quotient;
  assign o_remainder    = r_remainder;
  assign o_div_by_zero  = r_div_by_zero;
  assign o_overflow     = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem         <= '0;
      r_quo         <= '0;
      r_d           <= '0;
      r_dvd_lo      <= '0;
      r_count       <= '0;
      r_ovf_u       <= 1'b0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (i_load) begin
        r_rem    <= w_dvd_mag[WIDTH_P-1:WIDTH_M];
        r_quo    <= w_dvd_mag[WIDTH_M-1:0];
        r_d      <= w_dvs_mag;
        r_dvd_lo <= i_dividend[WIDTH_M-1:0];
        r_count  <= '0;
        r_ovf_u  <= (w_dvd_mag[WIDTH_P-1:WIDTH_M] >= w_dvs_mag);
        r_sign_q <= i_dividend[WIDTH_P-1] ^ i_divisor[WIDTH_M-1];
        r_sign_r <= i_dividend[WIDTH_P-1];
        r_dz     <= (i_divisor == '0);
      end else if (i_step) begin
        if (!w_trial[WIDTH_M+1]) begin
          r_rem <= w_trial[WIDTH_M-1:0];
          r_quo <= {r_quo[WIDTH_M-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[WIDTH_M-1:0];
          r_quo <= {r_quo[WIDTH_M-2:0], 1'b0};
        end
        r_count <= r_count + CNT_W'(1);
      end
      if (i_fix) begin
        r_div_by_zero <= r_dz;
        if (r_dz) begin
          r_quotient  <= '0;
          r_remainder <= r_dvd_lo;
          r_overflow  <= 1'b0;
        end else if (w_ovf) begin
          r_quotient  <= '0;
          r_remainder <= '0;
          r_overflow  <= 1'b1;
        end else begin
          r_quotient  <= r_sign_q ? (~r_quo + WIDTH_M'(1)) : r_quo;
          r_remainder <= r_sign_r ? (~r_rem + WIDTH_M'(1)) : r_rem;
          r_overflow  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - start-driven signed 32/16 sequential divider, FSM plus datapath
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH_M = DIV_WIDTH_M,
  parameter int WIDTH_P = DIV_WIDTH_P
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH_P-1:0] dividend,
  input  logic [WIDTH_M-1:0] divisor,
  output logic               ready,
  output logic               valid,
  output logic [WIDTH_M-1:0] quotient,
  output logic [WIDTH_M-1:0] remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  state_t r_state;
  state_t w_next;
  logic   r_valid;
  logic   w_load;
  logic   w_step;
  logic   w_fix;
  logic   w_count_done;
  logic   w_divisor_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_fix;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = w_divisor_zero ? FIX : CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (w_count_done) w_next = FIX;
      end
      FIX: begin
        w_fix  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign ready = (r_state == IDLE);
  assign valid = r_valid;

  seq_divider_datapath #(
    .WIDTH_M(WIDTH_M),
    .WIDTH_P(WIDTH_P),
    .CNT_W  ($clog2(WIDTH_M) + 1)
  ) u_datapath (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load        (w_load),
    .i_step        (w_step),
    .i_fix         (w_fix),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_count_done  (w_count_done),
    .o_divisor_zero(w_divisor_zero),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (div_by_zero),
    .o_overflow    (overflow)
  );

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        ready;
  logic        valid;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t_acc = 0;

  seq_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .valid      (valid),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    exp_t   e;
    longint sa, sd, q, r;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    e.a = a; e.b = b; e.dz = 1'b0; e.ov = 1'b0; e.lat = 17;
    if (b == 16'h0) begin
      e.dz = 1'b1; e.q = 16'h0; e.r = a[15:0]; e.lat = 1;
    end else begin
      q = sa / sd;
      r = sa % sd;
      if (q > 32767 || q < -32768) begin
        e.ov = 1'b1; q = 0; r = 0;
      end
      e.q = q[15:0];
      e.r = r[15:0];
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [15:0] b);
    sb.push_back(model(a, b));
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    t_acc = cyc;
    start = 1'b0;
  endtask

  task automatic get_result(input string tag);
    exp_t   e;
    int     n;
    longint lhs;
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (valid !== 1'b1 || sb.size() == 0) begin
      bad++;
      $display("FAIL %s no_valid: valid=%b queued=%0d required valid=1", tag, valid, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    total++;
    if ((cyc - t_acc) !== e.lat) begin
      bad++; $display("FAIL %s latency: got=%0d required=%0d", tag, cyc - t_acc, e.lat);
    end
    total++;
    if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dz, e.ov}) begin
      bad++;
      $display("FAIL %s result %h/%h: got q=%h r=%h dz=%b ov=%b required q=%h r=%h dz=%b ov=%b",
               tag, e.a, e.b, quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dz, e.ov);
    end
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_at_valid: got=%b required=1", tag, ready);
    end
    if (!e.dz && !e.ov) begin
      lhs = longint'($signed(quotient)) * longint'($signed(e.b)) + longint'($signed(remainder));
      total++;
      if (lhs !== longint'($signed(e.a))) begin
        bad++; $display("FAIL %s identity: got=%0d required=%0d", tag, lhs, longint'($signed(e.a)));
      end
    end
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (valid === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL %s spurious_valid: got=%0d required=0", tag, seen);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({ready, valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: got rdy=%b v=%b q=%h r=%h dz=%b ov=%b required rdy=1 v=0 q=0 r=0 dz=0 ov=0",
               ready, valid, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    issue(32'd100, 16'd7);
    get_result("basic_100_7");
  endtask

  task automatic test_signs();
    logic [31:0] av[3];
    logic [15:0] bv[3];
    av = '{-32'sd100, 32'sd100, -32'sd100};
    bv = '{16'sd7, -16'sd7, -16'sd7};
    for (int i = 0; i < 3; i++) begin
      issue(av[i], bv[i]);
      get_result($sformatf("signs_%0d", i));
    end
  endtask

  task automatic test_div_zero();
    issue(32'h0001_2345, 16'h0);
    get_result("div_zero");
  endtask

  task automatic test_overflow();
    logic [31:0] av[4];
    logic [15:0] bv[4];
    av = '{32'h0000_8000, 32'hFFFF_8000, 32'h8000_0000, 32'h0001_0000};
    bv = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0001};
    for (int i = 0; i < 4; i++) begin
      issue(av[i], bv[i]);
      get_result($sformatf("ovf_%0d", i));
    end
  endtask

  task automatic test_ignore_start();
    issue(32'd1000, 16'd3);
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b1; dividend = 32'd77; divisor = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL ignore_start busy: got ready=%b required=0", ready);
    end
    get_result("ignore_start");
    quiet_window("ignore_start", 25);
  endtask

  task automatic test_back_to_back();
    issue(-32'sd123456, 16'sd321);
    get_result("b2b_first");
    issue(32'sd99999, -16'sd17);
    get_result("b2b_second");
    issue(32'h0000_0042, 16'h0);
    get_result("b2b_dz");
  endtask

  task automatic test_reset_mid();
    issue(32'd5000, 16'd9);
    repeat (8) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ready, valid, quotient} !== {1'b1, 1'b0, 16'h0}) begin
      bad++; $display("FAIL reset_mid: got rdy=%b v=%b q=%h required rdy=1 v=0 q=0", ready, valid, quotient);
    end
    void'(sb.pop_back());
    @(negedge clk); rst_n = 1'b1;
    quiet_window("reset_mid", 25);
  endtask

  task automatic test_random(input int n);
    logic [31:0] a;
    logic [15:0] b;
    logic [15:0] q16;
    longint      p, mag, off;
    for (int i = 0; i < n; i++) begin
      b = 16'($urandom);
      if (i % 50 == 0) b = 16'h0;
      case (i % 3)
        0: a = $urandom;
        1: begin
          q16 = 16'($urandom);
          p   = longint'($signed(q16)) * longint'($signed(b));
          mag = longint'($signed(b));
          if (mag < 0) mag = -mag;
          off = (mag == 0) ? 0 : longint'($urandom % 32'(mag));
          p   = (p < 0) ? p - off : p + off;
          a   = p[31:0];
        end
        default: a = {{16{b[3]}}, 16'($urandom)};
      endcase
      issue(a, b);
      get_result("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
